// File: rtl/sna_axi_request_master.sv
// sna_axi_request_master: collects header/address/data flits into one request and runs it as a single AXI4-Lite transaction.
module sna_axi_request_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flit_valid,
  output logic        flit_ready,
  input  logic [1:0]  flit_type,
  input  logic        flit_read,
  input  logic [3:0]  flit_pov_addr,
  input  logic [31:0] flit_addr,
  input  logic [31:0] flit_data,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_read,
  output logic [3:0]  rsp_pov_addr,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_resp,
  output logic        proto_err
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, WB, RD_A, RD_R, RSP} state_t;
  state_t state, state_n;
  logic        read_q;
  logic [3:0]  pov_q;
  logic [31:0] addr_q, data_q;
  logic        acc, is_hdr, is_addr, is_data, err_n, awvalid_n, wvalid_n;
  assign flit_ready   = (state == IDLE) | (state == ADDR) | (state == DATA);
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = data_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;
  assign rsp_read     = read_q;
  assign rsp_pov_addr = pov_q;
  always_comb begin
    acc     = flit_valid & flit_ready;
    is_hdr  = flit_type == 2'b10;
    is_addr = flit_type == 2'b00;
    is_data = flit_type == 2'b01;
    state_n = state;
    case (state)
      IDLE: state_n = acc & is_hdr ? ADDR : IDLE;
      ADDR: state_n = acc & is_addr ? (read_q ? RD_A : DATA) : ADDR;
      DATA: state_n = acc & is_hdr ? ADDR : acc & is_data ? WR : DATA;
      WR:   state_n = (~m_axi_awvalid | m_axi_awready) & (~m_axi_wvalid | m_axi_wready) ? WB : WR;
      WB:   state_n = m_axi_bvalid ? RSP : WB;
      RD_A: state_n = m_axi_arready ? RD_R : RD_A;
      RD_R: state_n = m_axi_rvalid ? RSP : RD_R;
      RSP:  state_n = rsp_ready ? IDLE : RSP;
    endcase
    // every accepted flit other than the one this state waits for is an error (a header in ADDR/DATA restarts)
    err_n = acc & (state == IDLE ? ~is_hdr : state == ADDR ? ~is_addr : ~is_data);
    // each write channel valid stays up independently until its own handshake
    awvalid_n = (state_n == WR) & ((state != WR) | (m_axi_awvalid & ~m_axi_awready));
    wvalid_n  = (state_n == WR) & ((state != WR) | (m_axi_wvalid & ~m_axi_wready));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      read_q        <= 1'b0;
      pov_q         <= 4'h0;
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 32'h0;
      rsp_resp      <= 2'b00;
      proto_err     <= 1'b0;
    end else begin
      state         <= state_n;
      m_axi_awvalid <= awvalid_n;
      m_axi_wvalid  <= wvalid_n;
      m_axi_bready  <= state_n == WB;
      m_axi_arvalid <= state_n == RD_A;
      m_axi_rready  <= state_n == RD_R;
      rsp_valid     <= state_n == RSP;
      proto_err     <= err_n;
      if (acc & is_hdr) begin
        read_q <= flit_read;
        pov_q  <= flit_pov_addr;
      end
      if (state == ADDR & acc & is_addr) addr_q <= flit_addr;
      if (state == DATA & acc & is_data) data_q <= flit_data;
      if (m_axi_bready & m_axi_bvalid) begin
        rsp_data <= 32'h0;
        rsp_resp <= m_axi_bresp;
      end
      if (m_axi_rready & m_axi_rvalid) begin
        rsp_data <= m_axi_rdata;
        rsp_resp <= m_axi_rresp;
      end
    end
  end
endmodule

// File: tb/tb_sna_axi_request_master.sv
// tb_sna_axi_request_master: directed vectors for the SNA request sequencer with hand-computed expectations.
module tb_sna_axi_request_master;
  logic clk = 0, rst_n = 0;
  logic flit_valid = 0, flit_ready, flit_read = 0;
  logic [1:0] flit_type = 0;
  logic [3:0] flit_pov_addr = 0;
  logic [31:0] flit_addr = 0, flit_data = 0;
  logic [31:0] awaddr, wdata, araddr, rdata = 0, rsp_data;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb, rsp_pov_addr;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready, arvalid, arready = 0, rvalid = 0, rready;
  logic [1:0] bresp = 0, rresp = 0, rsp_resp;
  logic rsp_valid, rsp_ready = 0, rsp_read, proto_err;
  int n_vec = 0, n_err = 0, b_cnt = 0, b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (bvalid & bready) b_cnt++;
  sna_axi_request_master dut (
    .clk(clk), .rst_n(rst_n), .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_type(flit_type),
    .flit_read(flit_read), .flit_pov_addr(flit_pov_addr), .flit_addr(flit_addr), .flit_data(flit_data),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_read(rsp_read), .rsp_pov_addr(rsp_pov_addr),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .proto_err(proto_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  // presents one flit for exactly one rising edge; returns at the following falling edge
  task automatic flit(input logic [1:0] t, input logic r, input logic [3:0] p, input logic [31:0] v);
    flit_valid = 1; flit_type = t; flit_read = r; flit_pov_addr = p; flit_addr = v; flit_data = v;
    step();
    flit_valid = 0;
  endtask
  initial begin
    step();
    step();
    chk("rst_flit_ready", flit_ready, 1);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst_n = 1;
    step();
    // zero-wait write
    flit(2'b10, 0, 4'h5, 0);
    chk("wr_hdr_err", proto_err, 0);
    flit(2'b00, 0, 0, 32'h10);
    chk("wr_addr_awvalid", awvalid, 0);
    awready = 1; wready = 1;
    flit(2'b01, 0, 0, 32'hDEADBEEF);
    chk("wr_awvalid", awvalid, 1);
    chk("wr_wvalid", wvalid, 1);
    chk("wr_awaddr", awaddr, 32'h10);
    chk("wr_wdata", wdata, 32'hDEADBEEF);
    chk("wr_wstrb", wstrb, 4'hF);
    chk("wr_awprot", awprot, 0);
    chk("wr_flit_ready", flit_ready, 0);
    step();
    awready = 0; wready = 0;
    chk("wr_valids_drop", {awvalid, wvalid}, 0);
    chk("wr_bready", bready, 1);
    bvalid = 1; bresp = 2'b00;
    step();
    bvalid = 0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_read", rsp_read, 0);
    chk("wr_rsp_pov", rsp_pov_addr, 4'h5);
    chk("wr_rsp_resp", rsp_resp, 0);
    chk("wr_rsp_data", rsp_data, 0);
    chk("wr_bready_drop", bready, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_idle_ready", flit_ready, 1);
    // read with 3 wait cycles, then 5 cycles of response backpressure
    flit(2'b10, 1, 4'hA, 0);
    flit(2'b00, 0, 0, 32'h20);
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, 32'h20);
    chk("rd_arprot", arprot, 0);
    chk("rd_awvalid", awvalid, 0);
    arready = 1;
    step();
    arready = 0;
    chk("rd_arvalid_drop", arvalid, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_rready", rready, 1);
      chk("rd_wait_flit_ready", flit_ready, 0);
      chk("rd_wait_rsp", rsp_valid, 0);
      step();
    end
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b10;
    step();
    rvalid = 0; rdata = 0; rresp = 0;
    chk("rd_rready_drop", rready, 0);
    for (int i = 0; i < 6; i++) begin
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_data", rsp_data, 32'h12345678);
      chk("rd_rsp_resp", rsp_resp, 2'b10);
      chk("rd_rsp_pov", rsp_pov_addr, 4'hA);
      chk("rd_rsp_read", rsp_read, 1);
      chk("rd_bp_flit_ready", flit_ready, 0);
      if (i == 5) rsp_ready = 1;
      step();
    end
    rsp_ready = 0;
    chk("rd_rsp_done", rsp_valid, 0);
    chk("rd_idle_ready", flit_ready, 1);
    // skewed write: wready immediate, awready after 4 cycles
    b0 = b_cnt;
    flit(2'b10, 0, 4'h1, 0);
    flit(2'b00, 0, 0, 32'h30);
    wready = 1;
    flit(2'b01, 0, 0, 32'h55);
    for (int i = 0; i < 4; i++) begin
      chk("sk_awvalid", awvalid, 1);
      chk("sk_wvalid", wvalid, i == 0 ? 1 : 0);
      chk("sk_bready_early", bready, 0);
      if (i == 3) awready = 1;
      step();
    end
    awready = 0; wready = 0;
    chk("sk_awvalid_drop", awvalid, 0);
    chk("sk_bready", bready, 1);
    bvalid = 1; bresp = 2'b01;
    step();
    bvalid = 0; bresp = 0;
    step();
    chk("sk_b_count", b_cnt - b0, 1);
    chk("sk_rsp_resp", rsp_resp, 2'b01);
    chk("sk_rsp_pov", rsp_pov_addr, 4'h1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("sk_rsp_done", rsp_valid, 0);
    // error recovery
    flit(2'b01, 0, 0, 32'h99);
    chk("er_data_in_idle", proto_err, 1);
    chk("er_idle_ready", flit_ready, 1);
    step();
    chk("er_pulse_once", proto_err, 0);
    flit(2'b10, 0, 4'h7, 0);
    chk("er_hdr1", proto_err, 0);
    flit(2'b11, 0, 0, 32'h77);
    chk("er_illegal", proto_err, 1);
    flit(2'b10, 1, 4'h3, 0);
    chk("er_hdr2", proto_err, 1);
    flit(2'b00, 0, 0, 32'h40);
    chk("er_addr_err", proto_err, 0);
    chk("er_arvalid", arvalid, 1);
    chk("er_awvalid", awvalid, 0);
    chk("er_araddr", araddr, 32'h40);
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rdata = 32'hCAFE0001;
    step();
    rvalid = 0; rdata = 0;
    chk("er_rsp_valid", rsp_valid, 1);
    chk("er_rsp_read", rsp_read, 1);
    chk("er_rsp_pov", rsp_pov_addr, 4'h3);
    chk("er_rsp_data", rsp_data, 32'hCAFE0001);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    // reset during WR
    flit(2'b10, 0, 4'h9, 0);
    flit(2'b00, 0, 0, 32'h50);
    flit(2'b01, 0, 0, 32'h66);
    chk("rw_awvalid", awvalid, 1);
    chk("rw_wvalid", wvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("rw_async_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rw_async_ready", flit_ready, 1);
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_rsp", rsp_valid, 0);
      chk("rw_idle", flit_ready, 1);
      chk("rw_no_valids", {awvalid, wvalid, bready}, 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
